// File: rtl/clkgen_multi.sv
// rtl/clkgen_multi.sv - multi-channel programmable clock/strobe generator
//
// Each channel divides clk by a run-time period P with high time H and emits
// one-cycle rise/fall strobes. Configuration writes land in a shadow register
// and move to the active set only at a period boundary, while stopped, or on
// sync, so clk_out never glitches.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   ch_en        in   per-channel run enable
//   sync         in   restart all enabled channels at phase 0
//   cfg_we       in   configuration write strobe
//   cfg_ch       in   target channel of the write
//   cfg_period   in   requested period in clk cycles
//   cfg_high     in   requested high time in clk cycles
//   cfg_pending  out  shadow written but not yet active
//   clk_out      out  divided clock, registered
//   rise_tick    out  pulse in first high cycle of clk_out
//   fall_tick    out  pulse in first low cycle of clk_out
module clkgen_multi #(
    parameter int NUM_CH         = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int DEFAULT_PERIOD = 50000,
    parameter int DEFAULT_HIGH   = 25000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 sync,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic [NUM_CH-1:0]    cfg_pending,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    rise_tick,
    output logic [NUM_CH-1:0]    fall_tick
);

    typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;

    // Period below 2 cannot hold both a high and a low cycle.
    function automatic logic [CNT_WIDTH-1:0] f_clamp_p(input logic [CNT_WIDTH-1:0] p);
        return (p < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : p;
    endfunction

    // High time kept within 1..P-1 so duty is never 0% or 100%.
    function automatic logic [CNT_WIDTH-1:0] f_clamp_h(input logic [CNT_WIDTH-1:0] p,
                                                       input logic [CNT_WIDTH-1:0] h);
        if (h == '0)
            return CNT_WIDTH'(1);
        else if (h >= p)
            return p - CNT_WIDTH'(1);
        else
            return h;
    endfunction

    localparam logic [CNT_WIDTH-1:0] DEF_P = f_clamp_p(CNT_WIDTH'(DEFAULT_PERIOD));
    localparam logic [CNT_WIDTH-1:0] DEF_H = f_clamp_h(DEF_P, CNT_WIDTH'(DEFAULT_HIGH));

    logic [CNT_WIDTH-1:0] w_cfg_p;
    logic [CNT_WIDTH-1:0] w_cfg_h;

    assign w_cfg_p = f_clamp_p(cfg_period);
    assign w_cfg_h = f_clamp_h(w_cfg_p, cfg_high);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t               r_state;
        state_t               w_state_nxt;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [CNT_WIDTH-1:0] w_cnt_nxt;
        logic [CNT_WIDTH-1:0] r_act_p;
        logic [CNT_WIDTH-1:0] r_act_h;
        logic [CNT_WIDTH-1:0] r_sh_p;
        logic [CNT_WIDTH-1:0] r_sh_h;
        logic                 r_pend;
        logic                 r_clk;
        logic                 r_rise;
        logic                 r_fall;
        logic                 w_wr;
        logic                 w_wrap;
        logic                 w_apply;
        logic                 w_start;
        logic                 w_clk_nxt;
        logic                 w_rise_nxt;
        logic                 w_fall_nxt;

        assign w_wr    = cfg_we && (int'(cfg_ch) == g) && (int'(cfg_ch) < NUM_CH);
        assign w_wrap  = (r_state == ST_RUNNING) && (r_cnt == r_act_p - CNT_WIDTH'(1));
        // Applied from the shadow as it stood before this cycle's write, so a
        // write coincident with a wrap or sync waits for the next boundary.
        assign w_apply = r_pend && (w_wrap || (r_state == ST_STOPPED) || sync);
        // sync on an enabled channel is handled exactly like a fresh start.
        assign w_start = ch_en[g] && ((r_state == ST_STOPPED) || sync);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_STOPPED;
                r_cnt   <= '0;
                r_clk   <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_clk   <= w_clk_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_act_p <= DEF_P;
                r_act_h <= DEF_H;
                r_sh_p  <= DEF_P;
                r_sh_h  <= DEF_H;
                r_pend  <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_act_p <= r_sh_p;
                    r_act_h <= r_sh_h;
                    r_pend  <= 1'b0;
                end
                if (w_wr) begin
                    r_sh_p <= w_cfg_p;
                    r_sh_h <= w_cfg_h;
                    r_pend <= 1'b1;
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            if (!ch_en[g]) begin
                w_state_nxt = ST_STOPPED;
                w_cnt_nxt   = '0;
            end else if (w_start) begin
                w_state_nxt = ST_RUNNING;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_WIDTH'(1);
            end
        end

        // At cnt==0 the output is high for any legal H, so comparing against
        // the pre-apply high time is safe on the wrap cycle.
        always_comb begin
            w_clk_nxt  = 1'b0;
            w_rise_nxt = 1'b0;
            w_fall_nxt = 1'b0;
            if (!ch_en[g]) begin
                w_fall_nxt = r_clk;
            end else if (w_start) begin
                w_clk_nxt  = 1'b1;
                w_rise_nxt = 1'b1;
            end else begin
                w_clk_nxt  = (w_cnt_nxt < r_act_h);
                w_rise_nxt = w_clk_nxt && !r_clk;
                w_fall_nxt = !w_clk_nxt && r_clk;
            end
        end

        assign cfg_pending[g] = r_pend;
        assign clk_out[g]     = r_clk;
        assign rise_tick[g]   = r_rise;
        assign fall_tick[g]   = r_fall;
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb/tb_clkgen_multi.sv - directed self-checking bench for clkgen_multi
module tb_clkgen_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ch_en;
    logic        sync;
    logic        cfg_we;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic [1:0]  cfg_pending;
    logic [1:0]  clk_out;
    logic [1:0]  rise_tick;
    logic [1:0]  fall_tick;

    int n_pass  = 0;
    int n_total = 0;

    clkgen_multi #(
        .NUM_CH(2), .CNT_WIDTH(16), .DEFAULT_PERIOD(12), .DEFAULT_HIGH(7)
    ) dut (
        .clk(clk), .reset(reset), .ch_en(ch_en), .sync(sync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
        .cfg_pending(cfg_pending), .clk_out(clk_out),
        .rise_tick(rise_tick), .fall_tick(fall_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic ch, input int p, input int h);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = 16'(p);
        cfg_high   = 16'(h);
    endtask

    task automatic test_reset();
        reset = 1'b1; ch_en = 2'b00; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = 1'b0; cfg_period = '0; cfg_high = '0;
        step(); step();
        n_total++;
        if ({clk_out, rise_tick, fall_tick, cfg_pending} !== 8'h00)
            $display("FAIL reset_outputs got=%h exp=00", {clk_out, rise_tick, fall_tick, cfg_pending});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [5:0] e;
        write_cfg(1'b0, 10, 5);
        step();
        cfg_we = 1'b0;
        n_total++;
        if (cfg_pending !== 2'b01) $display("FAIL basic_pend_set got=%b exp=01", cfg_pending);
        else n_pass++;
        step();
        n_total++;
        if (cfg_pending !== 2'b00) $display("FAIL basic_pend_clr got=%b exp=00", cfg_pending);
        else n_pass++;
        ch_en = 2'b01;
        for (int k = 0; k < 20; k++) begin
            step();
            e = {1'b0, 1'((k % 10) < 5), 1'b0, 1'((k % 10) == 0), 1'b0, 1'((k % 10) == 5)};
            n_total++;
            if ({clk_out, rise_tick, fall_tick} !== e)
                $display("FAIL basic_k%0d got=%b exp=%b", k, {clk_out, rise_tick, fall_tick}, e);
            else n_pass++;
        end
    endtask

    task automatic test_midperiod();
        logic [5:0] e;
        step(); step(); step();
        write_cfg(1'b0, 4, 1);
        step();
        cfg_we = 1'b0;
        for (int c = 3; c < 10; c++) begin
            if (c > 3) step();
            n_total++;
            if ({cfg_pending[0], clk_out[0]} !== {1'b1, 1'(c < 5)})
                $display("FAIL mid_old_c%0d got=%b exp=%b", c, {cfg_pending[0], clk_out[0]}, {1'b1, 1'(c < 5)});
            else n_pass++;
        end
        for (int k = 0; k < 8; k++) begin
            step();
            e = {1'b0, 1'((k % 4) == 0), 1'b0, 1'((k % 4) == 0), 1'b0, 1'((k % 4) == 1)};
            n_total++;
            if ({clk_out, rise_tick, fall_tick} !== e || cfg_pending !== 2'b00)
                $display("FAIL mid_new_k%0d got=%b/%b exp=%b/00", k, {clk_out, rise_tick, fall_tick}, cfg_pending, e);
            else n_pass++;
        end
    endtask

    task automatic test_clamp();
        write_cfg(1'b0, 1, 0);
        step();
        cfg_we = 1'b0;
        n_total++;
        if ({cfg_pending[0], clk_out[0]} !== 2'b11)
            $display("FAIL clamp_wrapwr got=%b exp=11", {cfg_pending[0], clk_out[0]});
        else n_pass++;
        for (int c = 1; c < 4; c++) begin
            step();
            n_total++;
            if ({cfg_pending[0], clk_out[0]} !== 2'b10)
                $display("FAIL clamp_hold_c%0d got=%b exp=10", c, {cfg_pending[0], clk_out[0]});
            else n_pass++;
        end
        for (int k = 0; k < 6; k++) begin
            step();
            n_total++;
            if ({cfg_pending[0], clk_out[0], rise_tick[0], fall_tick[0]} !== {1'b0, 1'(k % 2 == 0), 1'(k % 2 == 0), 1'(k % 2 == 1)})
                $display("FAIL clamp_p2_k%0d got=%b", k, {cfg_pending[0], clk_out[0], rise_tick[0], fall_tick[0]});
            else n_pass++;
        end
        write_cfg(1'b0, 6, 9);
        step();
        cfg_we = 1'b0;
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            n_total++;
            if ({cfg_pending[0], clk_out[0], fall_tick[0]} !== {1'b0, 1'((k % 6) < 5), 1'((k % 6) == 5)})
                $display("FAIL clamp_h5_k%0d got=%b", k, {cfg_pending[0], clk_out[0], fall_tick[0]});
            else n_pass++;
        end
    endtask

    task automatic test_sync();
        logic [3:0] e;
        ch_en = 2'b00;
        write_cfg(1'b0, 8, 4);
        step();
        write_cfg(1'b1, 12, 6);
        step();
        cfg_we = 1'b0;
        step();
        ch_en = 2'b01;
        step(); step(); step();
        ch_en = 2'b11;
        step(); step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int t = 0; t <= 24; t++) begin
            if (t > 0) step();
            e = {1'((t % 12) < 6), 1'((t % 8) < 4), 1'((t % 12) == 0), 1'((t % 8) == 0)};
            n_total++;
            if ({clk_out, rise_tick} !== e)
                $display("FAIL sync_t%0d got=%b exp=%b", t, {clk_out, rise_tick}, e);
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        ch_en = 2'b10;
        step();
        n_total++;
        if ({clk_out[0], rise_tick[0], fall_tick[0]} !== 3'b001)
            $display("FAIL drop_fall got=%b exp=001", {clk_out[0], rise_tick[0], fall_tick[0]});
        else n_pass++;
        step();
        n_total++;
        if ({clk_out[0], rise_tick[0], fall_tick[0]} !== 3'b000)
            $display("FAIL drop_quiet got=%b exp=000", {clk_out[0], rise_tick[0], fall_tick[0]});
        else n_pass++;
        ch_en = 2'b11;
        for (int k = 0; k < 8; k++) begin
            step();
            n_total++;
            if ({clk_out[0], rise_tick[0]} !== {1'(k < 4), 1'(k == 0)})
                $display("FAIL reen_k%0d got=%b exp=%b", k, {clk_out[0], rise_tick[0]}, {1'(k < 4), 1'(k == 0)});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        step(); step();
        reset = 1'b1;
        write_cfg(1'b0, 3, 1);
        step();
        n_total++;
        if ({clk_out, rise_tick, fall_tick, cfg_pending} !== 8'h00)
            $display("FAIL rstmid_outputs got=%h exp=00", {clk_out, rise_tick, fall_tick, cfg_pending});
        else n_pass++;
        reset  = 1'b0;
        cfg_we = 1'b0;
        ch_en  = 2'b01;
        for (int k = 0; k < 13; k++) begin
            step();
            e = {1'b0, 1'((k % 12) < 7), 1'b0, 1'((k % 12) == 0), 1'b0, 1'((k % 12) == 7), 2'b00};
            n_total++;
            if ({clk_out, rise_tick, fall_tick, cfg_pending} !== e)
                $display("FAIL rstmid_dflt_k%0d got=%b exp=%b", k, {clk_out, rise_tick, fall_tick, cfg_pending}, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midperiod();
        test_clamp();
        test_sync();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
